// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared constants and types for the iterative multiply/divide unit.
// Revision : 1.0  initial release
// ============================================================================
package mdu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mdu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq_if
// Purpose  : Request/result and shared-ALU signals of the multiply/divide unit.
// Revision : 1.0  initial release
// ============================================================================
interface mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic             alu_own;
    logic [2:0]       alu_ctl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Core/pipeline side: issues requests, owns the ALU result path.
    modport master (
        output start, op, src_a, src_b, alu_result,
        input  busy, done, alu_own, alu_ctl, alu_a, alu_b, hi, lo
    );

    // Sequencer side.
    modport slave (
        input  start, op, src_a, src_b, alu_result,
        output busy, done, alu_own, alu_ctl, alu_a, alu_b, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : Shared 32-bit combinational ALU of the core (and/or/add/sub).
// Revision : 1.0  initial release
// ============================================================================
module alu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic [2:0]       i_ctl,
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic      [WIDTH-1:0] o_y
);
    always_comb begin
        o_y = '0;
        case (i_ctl)
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_ADD: o_y = i_a + i_b;
            ALU_SUB: o_y = i_a - i_b;
            default: o_y = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/mdu_cb_gen.sv
`default_nettype none
// ============================================================================
// Module   : mdu_cb_gen
// Purpose  : Recovers the ALU carry-out (add) or borrow-out (sub) from MSBs.
// Revision : 1.0  initial release
// ============================================================================
module mdu_cb_gen (
    input  wire logic i_a31,
    input  wire logic i_b31,
    input  wire logic i_r31,
    input  wire logic i_sub,
    output logic      o_cb
);
    logic w_carry;
    logic w_borrow;

    always_comb begin
        w_carry  = (i_a31 & i_b31) | ((i_a31 | i_b31) & ~i_r31);
        w_borrow = (~i_a31 & i_b31) | ((~i_a31 | i_b31) & i_r31);
        o_cb     = i_sub ? w_borrow : w_carry;
    end
endmodule
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq
// Purpose  : Iterative MULTU/DIVU sequencer, one shared-ALU add/sub per cycle.
// Revision : 1.0  initial release
// ============================================================================
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    mdu_seq_if.slave  bus
);
    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [c_cnt_w-1:0] r_count;
    logic               r_op;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_own;

    logic               w_run;
    logic [WIDTH-1:0]   w_t;
    logic [2:0]         w_alu_ctl;
    logic [WIDTH-1:0]   w_alu_a;
    logic [WIDTH-1:0]   w_alu_b;
    logic               w_cb;

    // ALU drive is a pure function of the registered state so it stays
    // parked at add/0/0 whenever the sequencer does not own the ALU.
    always_comb begin
        w_run     = (r_state == RUN);
        w_t       = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
        w_alu_ctl = ALU_ADD;
        w_alu_a   = '0;
        w_alu_b   = '0;
        if (w_run) begin
            if (r_op == OP_DIVU) begin
                w_alu_ctl = ALU_SUB;
                w_alu_a   = w_t;
                w_alu_b   = r_opnd;
            end else begin
                w_alu_a   = r_hi;
                w_alu_b   = r_lo[0] ? r_opnd : '0;
            end
        end
    end

    mdu_cb_gen u_cb_gen (
        .i_a31 (w_alu_a[WIDTH-1]),
        .i_b31 (w_alu_b[WIDTH-1]),
        .i_r31 (bus.alu_result[WIDTH-1]),
        .i_sub (r_op),
        .o_cb  (w_cb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_op    <= OP_MULTU;
            r_opnd  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_own   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_opnd  <= (bus.op == OP_DIVU) ? bus.src_b : bus.src_a;
                        r_count <= '0;
                        r_hi    <= '0;
                        r_lo    <= (bus.op == OP_DIVU) ? bus.src_a : bus.src_b;
                        r_busy  <= 1'b1;
                        r_own   <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_count <= r_count + 1'b1;
                    if (r_op == OP_DIVU) begin
                        // A set hi[31] means the 33-bit partial remainder
                        // already exceeds any 32-bit divisor.
                        if (r_hi[WIDTH-1] || !w_cb) begin
                            r_hi <= bus.alu_result;
                            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_hi <= w_t;
                            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_hi <= {w_cb, bus.alu_result[WIDTH-1:1]};
                        r_lo <= {bus.alu_result[0], r_lo[WIDTH-1:1]};
                    end
                    if (r_count == c_last) begin
                        r_own   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_own   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.alu_own = r_own;
    assign bus.alu_ctl = w_alu_ctl;
    assign bus.alu_a   = w_alu_a;
    assign bus.alu_b   = w_alu_b;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_seq
// Purpose  : Self-checking bench for mdu_seq driving the real shared ALU.
// Revision : 1.0  initial release
// ============================================================================
module tb_mdu_seq;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    mdu_seq_if #(.WIDTH(32)) bus ();

    mdu_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alu #(.WIDTH(32)) u_alu (
        .i_ctl (bus.alu_ctl),
        .i_a   (bus.alu_a),
        .i_b   (bus.alu_b),
        .o_y   (bus.alu_result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required summary");
        $fatal(1);
    end

    // Reference: plain 64-bit product / integer division.
    function automatic logic [63:0] ref_result(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (op == OP_MULTU) begin
            p = 64'(a) * 64'(b);
        end else if (b == 32'd0) begin
            p = {a, 32'hFFFF_FFFF};
        end else begin
            p = {a % b, a / b};
        end
        return p;
    endfunction

    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_n, input bit start_in_done,
                          output int lat, output int busy_cnt, output int own_cnt,
                          output int done_cnt, output logic [31:0] hi_o, output logic [31:0] lo_o);
        lat = 0; busy_cnt = 0; own_cnt = 0; done_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.src_a = $urandom; bus.src_b = $urandom;
        for (int n = 1; n <= 40; n++) begin
            if (bus.busy)    busy_cnt++;
            if (bus.alu_own) own_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (lat == 0) lat = n;
            end
            if (n == inj_n) begin
                bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd9; bus.src_b = 32'd3;
            end else if (start_in_done && bus.done) begin
                bus.start = 1'b1; bus.op = ~op; bus.src_a = $urandom; bus.src_b = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        hi_o = bus.hi;
        lo_o = bus.lo;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.op = 1'b0; bus.src_a = '0; bus.src_b = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({bus.busy, bus.done, bus.alu_own} !== 3'b000) $display("FAIL reset_flags: got %b, required 000", {bus.busy, bus.done, bus.alu_own});
        else n_pass++;
        n_total++;
        if ({bus.hi, bus.lo} !== 64'd0) $display("FAIL reset_hilo: got %h, required 0", {bus.hi, bus.lo});
        else n_pass++;
        n_total++;
        if ({bus.alu_ctl, bus.alu_a, bus.alu_b} !== {ALU_ADD, 64'd0}) $display("FAIL reset_alu: got ctl=%b a=%h b=%h, required 010/0/0", bus.alu_ctl, bus.alu_a, bus.alu_b);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string name, input logic op, input logic [31:0] a, input logic [31:0] b);
        int lat, bc, oc, dc;
        logic [31:0] h, l;
        logic [63:0] exp;
        run_op(op, a, b, 0, 1'b0, lat, bc, oc, dc, h, l);
        exp = ref_result(op, a, b);
        n_total++;
        if ({h, l} !== exp) $display("FAIL %s_result: got hi=%h lo=%h, required hi=%h lo=%h", name, h, l, exp[63:32], exp[31:0]);
        else n_pass++;
        n_total++;
        if (lat !== 33 || dc !== 1) $display("FAIL %s_latency: got lat=%0d done_pulses=%0d, required 33/1", name, lat, dc);
        else n_pass++;
    endtask

    task automatic test_multu_basic();
        int lat, bc, oc, dc;
        logic [31:0] h, l;
        run_op(OP_MULTU, 32'd7, 32'd6, 0, 1'b0, lat, bc, oc, dc, h, l);
        n_total++;
        if (h !== 32'd0 || l !== 32'd42) $display("FAIL multu_7x6: got hi=%h lo=%h, required 0/42", h, l);
        else n_pass++;
        n_total++;
        if (lat !== 33) $display("FAIL multu_latency: got %0d, required 33", lat);
        else n_pass++;
        n_total++;
        if (bc !== 33 || oc !== 32) $display("FAIL multu_busy_own: got busy=%0d own=%0d cycles, required 33/32", bc, oc);
        else n_pass++;
        n_total++;
        if ({bus.busy, bus.alu_ctl, bus.alu_a, bus.alu_b} !== {1'b0, ALU_ADD, 64'd0}) $display("FAIL idle_alu: got busy=%b ctl=%b a=%h b=%h, required 0/010/0/0", bus.busy, bus.alu_ctl, bus.alu_a, bus.alu_b);
        else n_pass++;
    endtask

    task automatic test_boundaries();
        check_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_total++;
        if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) $display("FAIL multu_max_const: got hi=%h lo=%h, required FFFFFFFE/00000001", bus.hi, bus.lo);
        else n_pass++;
        check_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
        n_total++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) $display("FAIL divu_100_7_const: got lo=%0d hi=%0d, required 14/2", bus.lo, bus.hi);
        else n_pass++;
        check_op("divu_msb", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000);
        n_total++;
        if (bus.lo !== 32'd1 || bus.hi !== 32'h7FFF_FFFF) $display("FAIL divu_msb_const: got lo=%h hi=%h, required 1/7FFFFFFF", bus.lo, bus.hi);
        else n_pass++;
        check_op("divu_zero", OP_DIVU, 32'd5, 32'd0);
        n_total++;
        if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd5) $display("FAIL divu_zero_const: got lo=%h hi=%h, required FFFFFFFF/5", bus.lo, bus.hi);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int lat, bc, oc, dc;
        logic [31:0] h, l;
        run_op(OP_MULTU, 32'd3, 32'd4, 10, 1'b0, lat, bc, oc, dc, h, l);
        n_total++;
        if (h !== 32'd0 || l !== 32'd12) $display("FAIL busy_start_result: got hi=%h lo=%h, required 0/12", h, l);
        else n_pass++;
        n_total++;
        if (dc !== 1 || bc !== 33 || lat !== 33) $display("FAIL busy_start_timing: got done=%0d busy=%0d lat=%0d, required 1/33/33", dc, bc, lat);
        else n_pass++;
    endtask

    task automatic test_start_in_done();
        int lat, bc, oc, dc;
        logic [31:0] h, l;
        run_op(OP_DIVU, 32'd1000, 32'd33, 0, 1'b1, lat, bc, oc, dc, h, l);
        n_total++;
        if (h !== 32'd10 || l !== 32'd30) $display("FAIL done_start_result: got hi=%0d lo=%0d, required 10/30", h, l);
        else n_pass++;
        n_total++;
        if (bc !== 33 || dc !== 1 || bus.busy !== 1'b0) $display("FAIL done_start_ignored: got busy_cycles=%0d done=%0d busy_now=%b, required 33/1/0", bc, dc, bus.busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd123456; bus.src_b = 32'd789;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 1; n < 15; n++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({bus.busy, bus.done, bus.alu_own} !== 3'b000 || {bus.hi, bus.lo} !== 64'd0 || bus.alu_ctl !== ALU_ADD)
            $display("FAIL reset_mid_op: got busy=%b done=%b own=%b hi=%h lo=%h ctl=%b, required 0/0/0/0/0/010",
                     bus.busy, bus.done, bus.alu_own, bus.hi, bus.lo, bus.alu_ctl);
        else n_pass++;
        rst = 1'b0;
        check_op("after_reset_2x2", OP_MULTU, 32'd2, 32'd2);
        n_total++;
        if (bus.lo !== 32'd4) $display("FAIL after_reset_lo: got %0d, required 4", bus.lo);
        else n_pass++;
    endtask

    task automatic test_random();
        logic        op;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            check_op(op ? "rand_divu" : "rand_multu", op, a, b);
        end
    endtask

    task automatic test_back_to_back();
        check_op("b2b_first", OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        check_op("b2b_second", OP_DIVU, 32'hDEAD_BEEF, 32'h0000_1234);
    endtask

    initial begin
        test_reset();
        test_multu_basic();
        test_boundaries();
        test_start_while_busy();
        test_start_in_done();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
